// File: rtl/spi_cs_ctrl.sv
// Purpose : chip-select sequencer wrapped around a byte-wide SPI master; frames up to MAX_BYTES_PER_CS bytes per CS assertion.
// Latency : first o_M_TX_DV CS_SETUP_CLKS cycles after CS falls; o_RX_DV one cycle after i_M_RX_DV.
// Backpr. : o_TX_Ready low while a byte is in flight or CS is in setup/hold/inactive; a busy master stalls issue and CS release.
//
// Ports:
//   i_Clk, i_Rst                    clock, asynchronous active-high reset
//   i_TX_Count/i_TX_Byte/i_TX_DV    user side: bytes in the transaction (first byte only), byte, valid pulse
//   o_TX_Ready                      user may pulse i_TX_DV
//   o_RX_Count/o_RX_Byte/o_RX_DV    received byte, its 1-based index in the transaction, valid pulse
//   o_M_TX_Byte/o_M_TX_DV           byte and start pulse to the SPI master
//   i_M_TX_Ready/i_M_RX_DV/i_M_RX_Byte  SPI master idle, byte-done pulse, received byte
//   o_SPI_CS_n                      active-low chip select
module spi_cs_ctrl #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 2,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [7:0]    o_M_TX_Byte,
    output logic          o_M_TX_DV,
    input  logic          i_M_TX_Ready,
    input  logic          i_M_RX_DV,
    input  logic [7:0]    i_M_RX_Byte,
    output logic          o_SPI_CS_n
);

    localparam int TMAX_A = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int TMAX   = (TMAX_A > CS_INACTIVE_CLKS) ? TMAX_A : CS_INACTIVE_CLKS;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT_RX,
        WAIT_USER,
        HOLD,
        INACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [7:0]    byte_q, byte_d;
    logic          cs_n_q, cs_n_d;
    logic          tx_ready_q, tx_ready_d;
    logic          m_tx_dv_q, m_tx_dv_d;
    logic [7:0]    m_tx_byte_q, m_tx_byte_d;
    logic          rx_dv_q, rx_dv_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [CW-1:0] rx_count_q, rx_count_d;

    logic setup_done, hold_done, inactive_done;

    // timer_q counts cycles already spent in the current state (0 on entry)
    assign setup_done    = (timer_q == TW'(CS_SETUP_CLKS - 1));
    assign hold_done     = (timer_q >= TW'(CS_HOLD_CLKS - 1));
    assign inactive_done = (timer_q == TW'(CS_INACTIVE_CLKS - 1));

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        rem_d       = rem_q;
        m_tx_dv_d   = 1'b0;
        m_tx_byte_d = m_tx_byte_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_count_d  = rx_count_q;

        case (state_q)
            IDLE: begin
                if (tx_ready_q && i_TX_DV && (i_TX_Count != '0)) begin
                    byte_d     = i_TX_Byte;
                    rem_d      = (i_TX_Count > CW'(MAX_BYTES_PER_CS)) ? CW'(MAX_BYTES_PER_CS)
                                                                      : i_TX_Count;
                    rx_count_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // Launch on the last setup cycle when the master is already idle so the
                // start pulse lands exactly CS_SETUP_CLKS cycles after CS falls; ISSUE
                // is only visited when the master is still busy at that point.
                if (setup_done) begin
                    if (i_M_TX_Ready) begin
                        m_tx_dv_d   = 1'b1;
                        m_tx_byte_d = byte_q;
                        state_d     = WAIT_RX;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_M_TX_Ready) begin
                    m_tx_dv_d   = 1'b1;
                    m_tx_byte_d = byte_q;
                    state_d     = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (i_M_RX_DV) begin
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_M_RX_Byte;
                    rx_count_d = rx_count_q + CW'(1);
                    rem_d      = rem_q - CW'(1);
                    state_d    = (rem_q == CW'(1)) ? HOLD : WAIT_USER;
                end
            end
            WAIT_USER: begin
                if (i_TX_DV) begin
                    byte_d  = i_TX_Byte;
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                if (hold_done && i_M_TX_Ready) begin
                    state_d = INACTIVE;
                end
            end
            INACTIVE: begin
                if (inactive_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready and CS are registered images of the state being entered.
        tx_ready_d = (state_d == IDLE) || (state_d == WAIT_USER);
        cs_n_d     = (state_d == IDLE) || (state_d == INACTIVE);

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rem_q       <= '0;
            byte_q      <= '0;
            cs_n_q      <= 1'b1;
            tx_ready_q  <= 1'b0;
            m_tx_dv_q   <= 1'b0;
            m_tx_byte_q <= '0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= '0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rem_q       <= rem_d;
            byte_q      <= byte_d;
            cs_n_q      <= cs_n_d;
            tx_ready_q  <= tx_ready_d;
            m_tx_dv_q   <= m_tx_dv_d;
            m_tx_byte_q <= m_tx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
        end
    end

    assign o_TX_Ready  = tx_ready_q;
    assign o_RX_Count  = rx_count_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Purpose : self-checking bench for spi_cs_ctrl with a loopback SPI master model and a byte scoreboard.
// Latency : master model answers each start pulse 6 cycles later.
// Backpr. : model drops its ready while a byte is in flight.
module tb_spi_cs_ctrl;

    localparam int MAXB = 2;
    localparam int SETC = 2;
    localparam int HLDC = 2;
    localparam int INAC = 2;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_byte;
    logic          tx_dv;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [7:0]    m_tx_byte;
    logic          m_tx_dv;
    logic          m_rdy;
    logic          m_rx_dv;
    logic [7:0]    m_rx_byte;
    logic [7:0]    m_shift;
    int            m_cnt;
    logic          spur_rx_dv;
    logic [7:0]    spur_rx_byte;
    logic          dut_m_rx_dv;
    logic [7:0]    dut_m_rx_byte;
    logic          cs_n;

    int n_cmp  = 0;
    int n_fail = 0;
    int mdv_seen = 0;
    int rx_seen  = 0;
    logic prev_mdv = 1'b0;
    logic prev_rdv = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_rx[$];

    always #5 clk = ~clk;

    assign dut_m_rx_dv   = m_rx_dv | spur_rx_dv;
    assign dut_m_rx_byte = spur_rx_dv ? spur_rx_byte : m_rx_byte;

    spi_cs_ctrl #(
        .MAX_BYTES_PER_CS(MAXB),
        .CS_SETUP_CLKS   (SETC),
        .CS_HOLD_CLKS    (HLDC),
        .CS_INACTIVE_CLKS(INAC)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_TX_Count  (tx_count),
        .i_TX_Byte   (tx_byte),
        .i_TX_DV     (tx_dv),
        .o_TX_Ready  (tx_ready),
        .o_RX_Count  (rx_count),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_M_TX_Byte (m_tx_byte),
        .o_M_TX_DV   (m_tx_dv),
        .i_M_TX_Ready(m_rdy),
        .i_M_RX_DV   (dut_m_rx_dv),
        .i_M_RX_Byte (dut_m_rx_byte),
        .o_SPI_CS_n  (cs_n)
    );

    // Loopback SPI master: MISO = MOSI, byte done 6 cycles after start; reset with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy     <= 1'b1;
            m_rx_dv   <= 1'b0;
            m_rx_byte <= 8'h00;
            m_shift   <= 8'h00;
            m_cnt     <= 0;
        end else begin
            m_rx_dv <= 1'b0;
            if (m_tx_dv) begin
                m_rdy   <= 1'b0;
                m_shift <= m_tx_byte;
                m_cnt   <= 6;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_rx_dv   <= 1'b1;
                    m_rx_byte <= m_shift;
                    m_rdy     <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Scoreboard: every start pulse and every received byte is popped against the queues.
    always @(negedge clk) begin
        if (m_tx_dv) begin
            mdv_seen++;
            check("mtx_width", int'(prev_mdv), 0);
            if (exp_tx.size() == 0) check("mtx_unexpected", 1, 0);
            else                    check("mtx_byte", int'(m_tx_byte), int'(exp_tx.pop_front()));
        end
        if (rx_dv) begin
            logic [15:0] e;
            rx_seen++;
            check("rx_width", int'(prev_rdv), 0);
            if (exp_rx.size() == 0) begin
                check("rx_unexpected", 1, 0);
            end else begin
                e = exp_rx.pop_front();
                check("rx_byte", int'(rx_byte), int'(e[7:0]));
                check("rx_count", int'(rx_count), int'(e[15:8]));
            end
        end
        prev_mdv = m_tx_dv;
        prev_rdv = rx_dv;
    end

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", int'(tx_ready), 1);
    endtask

    task automatic run_txn(input int cnt, input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input bit spur);
        int nb, n, k, m0, bad;
        logic [7:0] last;
        nb = (cnt > MAXB) ? MAXB : cnt;
        wait_ready();
        m0 = mdv_seen;
        exp_tx.push_back(b0);
        exp_rx.push_back({8'd1, b0});
        tx_count = CW'(cnt);
        tx_byte  = b0;
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        check("ready_drop", int'(tx_ready), 0);
        check("rx_count_clr", int'(rx_count), 0);
        n = 0;
        k = 0;
        while (!m_tx_dv && k < 100) begin
            if (!cs_n) n++;
            if (spur && k == 0) begin
                tx_dv    = 1'b1;
                tx_byte  = 8'hFF;
                tx_count = CW'(1);
            end else begin
                tx_dv = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        tx_dv = 1'b0;
        check("setup_clks", n, SETC);
        if (spur) begin
            tx_dv   = 1'b1;
            tx_byte = 8'h5A;
            @(negedge clk);
            tx_dv = 1'b0;
        end
        last = b0;
        if (nb == 2) begin
            bad = 0;
            k   = 0;
            while (!tx_ready && k < 100) begin
                if (cs_n) bad++;
                @(negedge clk);
                k++;
            end
            check("wait_user_ready", int'(tx_ready), 1);
            check("mid_rx_count", int'(rx_count), 1);
            if (spur) begin
                spur_rx_dv   = 1'b1;
                spur_rx_byte = 8'h77;
                @(negedge clk);
                spur_rx_dv = 1'b0;
            end
            repeat (gap) begin
                if (cs_n) bad++;
                @(negedge clk);
            end
            check("cs_low_gap", bad, 0);
            check("rx_byte_held", int'(rx_byte), int'(b0));
            exp_tx.push_back(b1);
            exp_rx.push_back({8'd2, b1});
            tx_byte  = b1;
            tx_count = '0;
            tx_dv    = 1'b1;
            @(negedge clk);
            tx_dv = 1'b0;
            check("ready_drop2", int'(tx_ready), 0);
            last = b1;
        end
        k = 0;
        while (!(rx_dv && rx_count == CW'(nb)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("final_rx_seen", int'(rx_dv), 1);
        n = 0;
        k = 0;
        while (!cs_n && k < 100) begin
            n++;
            @(negedge clk);
            k++;
        end
        check("hold_clks", n, HLDC);
        n = 0;
        k = 0;
        while (!tx_ready && k < 100) begin
            if (cs_n) n++;
            @(negedge clk);
            k++;
        end
        check("inactive_clks", n, INAC);
        check("rx_count_final", int'(rx_count), nb);
        check("rx_byte_final", int'(rx_byte), int'(last));
        check("mtx_pulses", mdv_seen - m0, nb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m0, r0, bad, k;
        rst          = 1'b1;
        tx_count     = '0;
        tx_byte      = 8'h00;
        tx_dv        = 1'b0;
        spur_rx_dv   = 1'b0;
        spur_rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_ready", int'(tx_ready), 0);
        check("rst_m_tx_dv", int'(m_tx_dv), 0);
        check("rst_rx_count", int'(rx_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(tx_ready), 1);

        run_txn(1, 8'hA5, 8'h00, 0, 1'b0);
        run_txn(2, 8'h3C, 8'hC3, 10, 1'b0);
        run_txn(3, 8'h11, 8'h22, 0, 1'b0);

        // Zero count is ignored in IDLE
        wait_ready();
        m0       = mdv_seen;
        tx_count = '0;
        tx_byte  = 8'hEE;
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        bad = 0;
        repeat (6) begin
            if (!cs_n || !tx_ready) bad++;
            @(negedge clk);
        end
        check("zero_cnt_idle", bad, 0);
        check("zero_cnt_mtx", mdv_seen - m0, 0);

        run_txn(2, 8'h81, 8'h7E, 3, 1'b1);

        // Reset while waiting for the master's byte
        wait_ready();
        exp_tx.push_back(8'h4B);
        exp_rx.push_back({8'd1, 8'h4B});
        tx_count = CW'(1);
        tx_byte  = 8'h4B;
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        k = 0;
        while (!m_tx_dv && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_started", int'(m_tx_dv), 1);
        repeat (2) @(negedge clk);
        check("rst_mid_cs_low", int'(cs_n), 0);
        #2;
        rst = 1'b1;
        exp_tx.delete();
        exp_rx.delete();
        #1;
        check("rst_mid_cs_n", int'(cs_n), 1);
        check("rst_mid_ready", int'(tx_ready), 0);
        check("rst_mid_m_tx_byte", int'(m_tx_byte), 0);
        check("rst_mid_rx_byte", int'(rx_byte), 0);
        check("rst_mid_rx_dv", int'(rx_dv), 0);
        check("rst_mid_m_tx_dv", int'(m_tx_dv), 0);
        r0 = rx_seen;
        m0 = mdv_seen;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_no_rx", rx_seen - r0, 0);
        check("rst_mid_no_mtx", mdv_seen - m0, 0);
        @(negedge clk);
        check("rst_mid_release_ready", int'(tx_ready), 1);
        run_txn(1, 8'h96, 8'h00, 0, 1'b0);

        repeat (5) @(negedge clk);
        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_rx_drained", exp_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cs_ctrl.md
SPI_CS_CTRL -- requirements
Module: spi_cs_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES_PER_CS, default 2, max bytes per chip-select assertion (>=1).
REQ-002 SHALL have parameter CS_SETUP_CLKS, default 2, i_Clk cycles with CS low before first byte is issued (>=1).
REQ-003 SHALL have parameter CS_HOLD_CLKS, default 2, i_Clk cycles with CS held low after last byte is received (>=1).
REQ-004 SHALL have parameter CS_INACTIVE_CLKS, default 2, i_Clk cycles with CS high before next transaction is accepted (>=1).
REQ-005 SHALL have port i_Clk, input, 1, single clock for all logic.
REQ-006 SHALL have port i_Rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port i_TX_Count, input, CW=$clog2(MAX_BYTES_PER_CS+1), bytes in the transaction; sampled only with the first i_TX_DV.
REQ-008 SHALL have port i_TX_Byte, input, 8, user byte to send.
REQ-009 SHALL have port i_TX_DV, input, 1, one-cycle valid pulse for i_TX_Byte.
REQ-010 SHALL have port o_TX_Ready, output, 1, controller accepts i_TX_DV.
REQ-011 SHALL have port o_RX_Count, output, CW, index of the last received byte within the current transaction.
REQ-012 SHALL have port o_RX_DV, output, 1, one-cycle pulse with o_RX_Byte.
REQ-013 SHALL have port o_RX_Byte, output, 8, byte received from the SPI master.
REQ-014 SHALL have port o_M_TX_Byte, output, 8, byte to the SPI master.
REQ-015 SHALL have port o_M_TX_DV, output, 1, one-cycle start pulse to the SPI master.
REQ-016 SHALL have port i_M_TX_Ready, input, 1, SPI master idle.
REQ-017 SHALL have port i_M_RX_DV, input, 1, SPI master byte-done pulse.
REQ-018 SHALL have port i_M_RX_Byte, input, 8, SPI master received byte.
REQ-019 SHALL have port o_SPI_CS_n, output, 1, active-low chip select.

Function
REQ-020 SHALL register all outputs; FSM states are IDLE, SETUP, ISSUE, WAIT_RX, WAIT_USER, HOLD, INACTIVE.
REQ-021 IDLE: CS_n=1 and o_TX_Ready=1; on i_TX_DV with i_TX_Count!=0, SHALL latch the byte and count (counts above MAX_BYTES_PER_CS clamp to MAX), clear o_RX_Count to 0 and o_TX_Ready, set CS_n=0 next cycle, and go to SETUP.
REQ-022 IDLE with i_TX_DV and i_TX_Count==0 SHALL be ignored, with no state change and CS staying high.
REQ-023 SETUP SHALL hold CS low for exactly CS_SETUP_CLKS cycles, then go to ISSUE.
REQ-024 ISSUE SHALL wait for i_M_TX_Ready=1, then drive o_M_TX_Byte=latched byte and pulse o_M_TX_DV for exactly one cycle, then go to WAIT_RX; no second pulse SHALL be issued for the same byte.
REQ-025 WAIT_RX: on i_M_RX_DV, SHALL pulse o_RX_DV with o_RX_Byte=i_M_RX_Byte on the next cycle, increment o_RX_Count (first byte=1), and decrement remaining.
REQ-026 After that decrement, remaining==0 SHALL go to HOLD; otherwise SHALL go to WAIT_USER with o_TX_Ready=1.
REQ-027 WAIT_USER: on i_TX_DV, SHALL latch i_TX_Byte (i_TX_Count ignored), clear o_TX_Ready, and go to ISSUE; CS stays low indefinitely while waiting.
REQ-028 HOLD SHALL keep CS low for CS_HOLD_CLKS cycles and until i_M_TX_Ready=1, then set CS_n=1 and go to INACTIVE.
REQ-029 INACTIVE SHALL keep CS high for CS_INACTIVE_CLKS cycles, then go to IDLE, with o_TX_Ready=1 from that cycle.
REQ-030 i_TX_DV outside IDLE/WAIT_USER and i_M_RX_DV outside WAIT_RX SHALL be ignored.
REQ-031 o_M_TX_DV and o_RX_DV SHALL never be high for more than one consecutive cycle; o_TX_Ready SHALL be 0 in the cycle after an accepted i_TX_DV.
REQ-032 o_RX_Count SHALL hold its final value until the next accepted transaction start.

Reset
REQ-033 i_Rst=1 SHALL immediately (asynchronously) force IDLE, o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_RX_DV=0, o_M_TX_Byte=0, o_RX_Byte=0, o_RX_Count=0.
REQ-034 The first clock after reset release SHALL set o_TX_Ready=1; reset mid-transaction SHALL abort with CS high and no further pulses, and the SPI master SHALL be reset at the same time.

Verification
REQ-035 Single byte: Count=1, byte 0xA5, loopback MISO=MOSI -> CS low 2 cycles before o_M_TX_DV, one o_RX_DV with 0xA5, o_RX_Count=1, CS high after hold, ready after 2 inactive cycles.
REQ-036 Two bytes: Count=2, bytes 0x3C, 0xC3, user delays second i_TX_DV by 10 cycles -> CS stays low throughout, o_RX_Count is 1 then 2, exactly two o_M_TX_DV pulses.
REQ-037 Clamp: Count=3 with MAX=2 -> exactly two bytes transferred, then HOLD.
REQ-038 Zero count: Count=0 with i_TX_DV in IDLE -> CS stays 1, no o_M_TX_DV, o_TX_Ready stays 1.
REQ-039 Spurious inputs: i_TX_DV during SETUP/WAIT_RX and i_M_RX_DV during WAIT_USER -> no effect on the byte, the counts or the outputs.
REQ-040 Reset mid-byte: i_Rst asserted in WAIT_RX -> CS_n=1 immediately, all outputs at reset values, and a new transaction after release works normally.
